// File: rtl/fma_pkg.sv
// Shared widths, operand layout, FSM states and field helpers for the FMA operand-prep front end.
package fma_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned SIG_W  = MAN_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned XP_W   = EXP_W + 2;
    localparam int unsigned CNT_W  = $clog2(SIG_W);

    // Exponent reported for a zero product; below every real product exponent
    localparam logic [XP_W-1:0] EXP_MIN = {1'b1, {(XP_W-1){1'b0}}};

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp_t;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    // Denormals flush to zero, so a zero exponent field gives a zero significand
    function automatic logic [SIG_W-1:0] unpack_sig(input logic [EXP_W-1:0] e,
                                                    input logic [MAN_W-1:0] f);
        return (e == '0) ? '0 : {1'b1, f};
    endfunction

    function automatic logic is_inf(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        return (&e) && (f == '0);
    endfunction

    function automatic logic is_nan(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        return (&e) && (f != '0);
    endfunction

endpackage

// File: rtl/fma_operand_prep_if.sv
// Operand/result handshake bundle for fma_operand_prep.
// nanOut/infOut exist only when FMA_SPECIAL_DETECT_EN is defined.
interface fma_operand_prep_if;
    import fma_pkg::*;

    logic              inValid;
    logic              inReady;
    fp_t               aIn;
    fp_t               bIn;
    fp_t               cIn;
    fp_t               dIn;
    logic              opIn;
    logic              outValid;
    logic              outReady;
    logic              abSign;
    logic              cdSign;
    logic              expComp;
    logic              signIfComp;
    logic              op;
    logic [XP_W-1:0]   expAB;
    logic [XP_W-1:0]   expCD;
    logic [PROD_W-1:0] manAB;
    logic [PROD_W-1:0] manCD;
`ifdef FMA_SPECIAL_DETECT_EN
    logic              nanOut;
    logic              infOut;
`endif

    modport master (
        output inValid, aIn, bIn, cIn, dIn, opIn, outReady,
        input  inReady, outValid, abSign, cdSign, expComp, signIfComp, op,
               expAB, expCD, manAB, manCD
`ifdef FMA_SPECIAL_DETECT_EN
        , input nanOut, infOut
`endif
    );

    modport slave (
        input  inValid, aIn, bIn, cIn, dIn, opIn, outReady,
        output inReady, outValid, abSign, cdSign, expComp, signIfComp, op,
               expAB, expCD, manAB, manCD
`ifdef FMA_SPECIAL_DETECT_EN
        , output nanOut, infOut
`endif
    );

endinterface

// File: rtl/fma_seq_mult.sv
// Sequential shift-add significand multiplier: loads on i_start, one partial product per cycle,
// o_done rises after SIG_W steps and holds with o_prod until the next start.
module fma_seq_mult
    import fma_pkg::*;
(
    input  logic              clk,
    input  logic              rstN,
    input  logic              i_start,
    input  logic [SIG_W-1:0]  i_x,
    input  logic [SIG_W-1:0]  i_y,
    output logic [PROD_W-1:0] o_prod,
    output logic              o_done
);

    logic [PROD_W-1:0] r_mcand;
    logic [PROD_W-1:0] r_acc;
    logic [SIG_W-1:0]  r_mplier;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= PROD_W'(i_x);
            r_mplier <= i_y;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(MAN_W)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign o_prod = r_acc;
    assign o_done = r_done;

endmodule

// File: rtl/fma_operand_prep.sv
// FMA front end: exact normalized a*b and c*d magnitudes plus the sign/compare flags for the sign stage.
// Define FMA_SPECIAL_DETECT_EN to add nanOut/infOut special-value detection.
module fma_operand_prep
    import fma_pkg::*;
(
    input  logic               clk,
    input  logic               rstN,
    fma_operand_prep_if.slave  bus
);

    state_t                  r_state;
    logic                    r_in_ready, r_out_valid;
    logic                    r_cap_ab_sign, r_cap_cd_sign, r_cap_op;
    logic signed [XP_W-1:0]  r_esum_ab, r_esum_cd;
    logic                    r_ab_sign, r_cd_sign, r_exp_comp, r_sign_if_comp, r_op;
    logic [XP_W-1:0]         r_exp_ab, r_exp_cd;
    logic [PROD_W-1:0]       r_man_ab, r_man_cd;

    logic                    w_accept, w_done, w_done_ab, w_done_cd;
    logic [SIG_W-1:0]        w_sig_a, w_sig_b, w_sig_c, w_sig_d;
    logic [PROD_W-1:0]       w_prod_ab, w_prod_cd, w_man_ab, w_man_cd;
    logic signed [XP_W-1:0]  w_esum_ab, w_esum_cd, w_exp_ab, w_exp_cd;
    logic                    w_norm_ab, w_norm_cd;

    assign w_accept = (r_state == IDLE) && bus.inValid;
    assign w_done   = w_done_ab & w_done_cd;

    assign w_sig_a = unpack_sig(bus.aIn.exp, bus.aIn.frac);
    assign w_sig_b = unpack_sig(bus.bIn.exp, bus.bIn.frac);
    assign w_sig_c = unpack_sig(bus.cIn.exp, bus.cIn.frac);
    assign w_sig_d = unpack_sig(bus.dIn.exp, bus.dIn.frac);

    // Unbiased product exponent before normalization: (eX - BIAS) + (eY - BIAS)
    assign w_esum_ab = XP_W'(bus.aIn.exp) + XP_W'(bus.bIn.exp) - XP_W'(2 * BIAS);
    assign w_esum_cd = XP_W'(bus.cIn.exp) + XP_W'(bus.dIn.exp) - XP_W'(2 * BIAS);

    fma_seq_mult u_mult_ab (
        .clk     (clk),
        .rstN    (rstN),
        .i_start (w_accept),
        .i_x     (w_sig_a),
        .i_y     (w_sig_b),
        .o_prod  (w_prod_ab),
        .o_done  (w_done_ab)
    );

    fma_seq_mult u_mult_cd (
        .clk     (clk),
        .rstN    (rstN),
        .i_start (w_accept),
        .i_x     (w_sig_c),
        .i_y     (w_sig_d),
        .o_prod  (w_prod_cd),
        .o_done  (w_done_cd)
    );

    // Product of two [1,2) significands lies in [1,4): either keep it or shift by one
    assign w_norm_ab = w_prod_ab[PROD_W-1];
    assign w_norm_cd = w_prod_cd[PROD_W-1];
    assign w_man_ab  = w_norm_ab ? w_prod_ab : {w_prod_ab[PROD_W-2:0], 1'b0};
    assign w_man_cd  = w_norm_cd ? w_prod_cd : {w_prod_cd[PROD_W-2:0], 1'b0};
    assign w_exp_ab  = (w_prod_ab == '0) ? EXP_MIN : r_esum_ab + XP_W'(w_norm_ab);
    assign w_exp_cd  = (w_prod_cd == '0) ? EXP_MIN : r_esum_cd + XP_W'(w_norm_cd);

`ifdef FMA_SPECIAL_DETECT_EN
    logic r_sp_nan, r_sp_ab_inf, r_sp_cd_inf, r_nan, r_inf;
    logic w_any_nan, w_ab_inf, w_cd_inf, w_inf_zero, w_nan_fin;

    assign w_any_nan  = is_nan(bus.aIn.exp, bus.aIn.frac) | is_nan(bus.bIn.exp, bus.bIn.frac)
                      | is_nan(bus.cIn.exp, bus.cIn.frac) | is_nan(bus.dIn.exp, bus.dIn.frac);
    assign w_ab_inf   = is_inf(bus.aIn.exp, bus.aIn.frac) | is_inf(bus.bIn.exp, bus.bIn.frac);
    assign w_cd_inf   = is_inf(bus.cIn.exp, bus.cIn.frac) | is_inf(bus.dIn.exp, bus.dIn.frac);
    assign w_inf_zero = (w_ab_inf && ((w_sig_a == '0) || (w_sig_b == '0)))
                      | (w_cd_inf && ((w_sig_c == '0) || (w_sig_d == '0)));
    // inf - inf when the effective sign of the cd term differs from ab
    assign w_nan_fin  = r_sp_nan | (r_sp_ab_inf & r_sp_cd_inf & (r_cap_ab_sign ^ r_cap_cd_sign ^ ~r_cap_op));

    assign bus.nanOut = r_nan;
    assign bus.infOut = r_inf;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state        <= IDLE;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_cap_ab_sign  <= 1'b0;
            r_cap_cd_sign  <= 1'b0;
            r_cap_op       <= 1'b0;
            r_esum_ab      <= '0;
            r_esum_cd      <= '0;
            r_ab_sign      <= 1'b0;
            r_cd_sign      <= 1'b0;
            r_exp_comp     <= 1'b0;
            r_sign_if_comp <= 1'b0;
            r_op           <= 1'b0;
            r_exp_ab       <= '0;
            r_exp_cd       <= '0;
            r_man_ab       <= '0;
            r_man_cd       <= '0;
`ifdef FMA_SPECIAL_DETECT_EN
            r_sp_nan       <= 1'b0;
            r_sp_ab_inf    <= 1'b0;
            r_sp_cd_inf    <= 1'b0;
            r_nan          <= 1'b0;
            r_inf          <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_cap_ab_sign <= bus.aIn.sign ^ bus.bIn.sign;
                    r_cap_cd_sign <= bus.cIn.sign ^ bus.dIn.sign;
                    r_cap_op      <= bus.opIn;
                    r_esum_ab     <= w_esum_ab;
                    r_esum_cd     <= w_esum_cd;
`ifdef FMA_SPECIAL_DETECT_EN
                    r_sp_nan      <= w_any_nan | w_inf_zero;
                    r_sp_ab_inf   <= w_ab_inf;
                    r_sp_cd_inf   <= w_cd_inf;
`endif
                    r_in_ready    <= 1'b0;
                    r_state       <= MUL;
                end
                MUL: if (w_done) begin
                    r_state <= NORM;
                end
                NORM: begin
                    r_ab_sign      <= r_cap_ab_sign;
                    r_cd_sign      <= r_cap_cd_sign;
                    r_op           <= r_cap_op;
                    r_exp_ab       <= w_exp_ab;
                    r_exp_cd       <= w_exp_cd;
                    r_man_ab       <= w_man_ab;
                    r_man_cd       <= w_man_cd;
                    r_exp_comp     <= (w_exp_ab > w_exp_cd);
                    r_sign_if_comp <= (w_exp_ab == w_exp_cd) && (w_man_ab > w_man_cd);
`ifdef FMA_SPECIAL_DETECT_EN
                    r_nan          <= w_nan_fin;
                    r_inf          <= (r_sp_ab_inf | r_sp_cd_inf) & ~w_nan_fin;
`endif
                    r_out_valid    <= 1'b1;
                    r_state        <= DONE;
                end
                DONE: if (bus.outReady) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.inReady    = r_in_ready;
    assign bus.outValid   = r_out_valid;
    assign bus.abSign     = r_ab_sign;
    assign bus.cdSign     = r_cd_sign;
    assign bus.expComp    = r_exp_comp;
    assign bus.signIfComp = r_sign_if_comp;
    assign bus.op         = r_op;
    assign bus.expAB      = r_exp_ab;
    assign bus.expCD      = r_exp_cd;
    assign bus.manAB      = r_man_ab;
    assign bus.manCD      = r_man_cd;

endmodule
